// File: rtl/ser_tx.sv
// ser_tx: byte-wide parallel-in, serial-out transmitter.
// A byte is accepted on a din_valid/din_ready handshake. It is shifted out MSB first, and each
// bit is held for DIV clocks. After the byte the line can idle low for GAP clocks. One further
// byte can be parked in a holding register while a byte is shifting, so valid data streams
// without bubbles.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   din[7:0]   in   byte offered for transfer
//   din_valid  in   din holds a valid byte
//   din_ready  out  byte can be accepted this cycle (0 while in reset)
//   sout       out  serial data, MSB first, 0 when not shifting
//   sout_stb   out  one-cycle capture strobe in the last cycle of each bit
//   busy       out  state is not IDLE
//   done       out  pulse with the 8th strobe of each byte
module ser_tx #(
    parameter int unsigned DIV = 1,  // clk cycles per bit, 1..256
    parameter int unsigned GAP = 0   // idle cycles after each byte, 0..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sout,
    output logic       sout_stb,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] DivLast = 8'(DIV - 1);
    localparam logic [7:0] GapLast = 8'(GAP - 1);
    localparam bit         NoGap   = (GAP == 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e     r_state, w_state_nxt;
    logic [7:0] r_shreg, w_shreg_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_divcnt, w_divcnt_nxt;
    logic [7:0] r_gapcnt, w_gapcnt_nxt;
    logic [7:0] r_hold, w_hold_nxt;
    logic       r_hold_full, w_hold_full_nxt;

    logic w_xfer;
    logic w_bit_end;
    logic w_byte_end;
    logic w_gap_end;
    logic w_next_byte;

    assign w_xfer      = din_valid & din_ready;
    assign w_bit_end   = (r_state == StShift) && (r_divcnt == DivLast);
    assign w_byte_end  = w_bit_end && (r_bitcnt == 3'd0);
    assign w_gap_end   = (r_state == StGap) && (r_gapcnt == GapLast);
    // Edge on which the line is free for the next byte (end of last bit, or end of gap).
    assign w_next_byte = (w_byte_end && NoGap) || w_gap_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_divcnt    <= '0;
            r_gapcnt    <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_divcnt    <= w_divcnt_nxt;
            r_gapcnt    <= w_gapcnt_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bitcnt_nxt    = r_bitcnt;
        w_divcnt_nxt    = r_divcnt;
        w_gapcnt_nxt    = r_gapcnt;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;

        unique case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_shreg_nxt  = din;
                    w_bitcnt_nxt = 3'd7;
                    w_divcnt_nxt = '0;
                    w_state_nxt  = StShift;
                end
            end
            StShift: begin
                if (w_bit_end) begin
                    w_divcnt_nxt = '0;
                    w_shreg_nxt  = {r_shreg[6:0], 1'b0};
                    w_bitcnt_nxt = r_bitcnt - 3'd1;
                    if (w_byte_end && !NoGap) begin
                        w_gapcnt_nxt = '0;
                        w_state_nxt  = StGap;
                    end
                end else begin
                    w_divcnt_nxt = r_divcnt + 8'd1;
                end
            end
            StGap: begin
                w_gapcnt_nxt = r_gapcnt + 8'd1;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // A byte offered while the line is busy is parked in the holding register.
        if (w_xfer && (r_state != StIdle)) begin
            w_hold_nxt      = din;
            w_hold_full_nxt = 1'b1;
        end

        // At the end of a byte or gap, restart from the held byte, or else from din directly
        // (the bypass path). This overrides the parking above. If neither is available, go idle.
        if (w_next_byte) begin
            w_divcnt_nxt = '0;
            w_bitcnt_nxt = 3'd7;
            w_gapcnt_nxt = '0;
            if (r_hold_full) begin
                w_shreg_nxt     = r_hold;
                w_hold_full_nxt = 1'b0;
                w_state_nxt     = StShift;
            end else if (w_xfer) begin
                w_shreg_nxt     = din;
                w_hold_full_nxt = 1'b0;
                w_state_nxt     = StShift;
            end else begin
                w_state_nxt = StIdle;
            end
        end
    end

    assign din_ready = rst & ~r_hold_full;
    assign sout      = (r_state == StShift) & r_shreg[7];
    assign sout_stb  = w_bit_end;
    assign done      = w_byte_end;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx. Three instances (DIV/GAP = 1/0, 4/0, 2/3) share the din/din_valid stimulus.
// Each instance is checked every cycle against a timeline model. The model is built from the
// accept time of each byte. A byte starts at max(accept+1, previous start + 8*DIV + GAP).
module tb_ser_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic [2:0] ready, sout, stb, busy, done;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 4 : 2;
        localparam int unsigned G = (g == 2) ? 3 : 0;
        ser_tx #(.DIV(D), .GAP(G)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din       (din),
            .din_valid (din_valid),
            .din_ready (ready[g]),
            .sout      (sout[g]),
            .sout_stb  (stb[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream serial-in register fed by instance 0.
    logic [7:0] ds = '0;
    always @(posedge clk) if (stb[0]) ds <= {ds[6:0], sout[0]};

    typedef struct {
        logic [7:0] b;
        int         a;  // cycle in which the byte was accepted
        int         s;  // first cycle its MSB is on sout
    } rec_t;

    rec_t mq[3][$];
    int   nf[3];
    int   dv[3] = '{1, 4, 2};
    int   gp[3] = '{0, 0, 3};

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [2:0] s_sout, s_stb, s_done, s_busy, s_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check(input int g, input logic [7:0] d, input logic v);
        int   dd, span, rel, bi, st;
        logic es, estb, ed, eb, er;
        logic [7:0] bb;
        dd   = dv[g];
        span = 8 * dd + gp[g];
        if (!rst) begin
            chk($sformatf("inst%0d outputs in reset", g),
                {31'd0, sout[g] | stb[g] | done[g] | busy[g] | ready[g]}, 32'd0);
            mq[g].delete();
            nf[g] = 0;
            return;
        end
        while (mq[g].size() > 0 && cyc >= mq[g][0].s + span) void'(mq[g].pop_front());
        es = 0; estb = 0; ed = 0; eb = 0; er = 1;
        for (int i = 0; i < mq[g].size(); i++) begin
            rel = cyc - mq[g][i].s;
            if (rel >= 0 && rel < 8 * dd) begin
                eb   = 1;
                bi   = rel / dd;
                bb   = mq[g][i].b;
                es   = bb[7-bi];
                estb = ((rel % dd) == dd - 1);
                ed   = estb && (bi == 7);
            end else if (rel >= 8 * dd && rel < span) begin
                eb = 1;
            end
            if (mq[g][i].a < cyc && cyc < mq[g][i].s) er = 0;
        end
        chk($sformatf("inst%0d sout", g),      {31'd0, sout[g]},  {31'd0, es});
        chk($sformatf("inst%0d sout_stb", g),  {31'd0, stb[g]},   {31'd0, estb});
        chk($sformatf("inst%0d done", g),      {31'd0, done[g]},  {31'd0, ed});
        chk($sformatf("inst%0d busy", g),      {31'd0, busy[g]},  {31'd0, eb});
        chk($sformatf("inst%0d din_ready", g), {31'd0, ready[g]}, {31'd0, er});
        if (v && er) begin
            st = (cyc + 1 > nf[g]) ? cyc + 1 : nf[g];
            mq[g].push_back('{b: d, a: cyc, s: st});
            nf[g] = st + span;
        end
    endtask

    // One clock cycle: drive at posedge+1, sample and model at posedge+4.
    task automatic cycle(input logic [7:0] d, input logic v);
        din       = d;
        din_valid = v;
        #3;
        s_sout = sout; s_stb = stb; s_done = done; s_busy = busy; s_ready = ready;
        for (int g = 0; g < 3; g++) model_check(g, d, v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int i = 0; i < 300 && !idle; i++) begin
            cycle(8'h00, 1'b0);
            idle = (s_busy == 3'b000);
        end
        chk("drain to idle", {31'd0, idle}, 32'd1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       so, st, dn, bz, rd;
    } vec_t;

    vec_t tab[10];

    initial begin
        int nstb, d1, d2, dk, bad, k;

        // 8'hA5 on instance 0 (DIV=1, GAP=0).
        tab[0] = '{8'hA5, 1, 0, 0, 0, 0, 1};
        tab[1] = '{8'h00, 0, 1, 1, 0, 1, 1};
        tab[2] = '{8'h00, 0, 0, 1, 0, 1, 1};
        tab[3] = '{8'h00, 0, 1, 1, 0, 1, 1};
        tab[4] = '{8'h00, 0, 0, 1, 0, 1, 1};
        tab[5] = '{8'h00, 0, 0, 1, 0, 1, 1};
        tab[6] = '{8'h00, 0, 1, 1, 0, 1, 1};
        tab[7] = '{8'h00, 0, 0, 1, 0, 1, 1};
        tab[8] = '{8'h00, 0, 1, 1, 1, 1, 1};
        tab[9] = '{8'h00, 0, 0, 0, 0, 0, 1};

        rst = 1'b0; din = '0; din_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0);
        rst = 1'b1;
        cycle(8'h00, 1'b0);
        chk("ready after reset release", {29'd0, s_ready}, 32'd7);
        chk("busy after reset release", {29'd0, s_busy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            cycle(tab[i].d, tab[i].v);
            chk($sformatf("vec%0d", i), {27'd0, s_sout[0], s_stb[0], s_done[0], s_busy[0],
                s_ready[0]}, {27'd0, tab[i].so, tab[i].st, tab[i].dn, tab[i].bz, tab[i].rd});
        end
        chk("downstream shreg", {24'd0, ds}, 32'hA5);
        drain();

        // 8'h81 at DIV=4: done 32 cycles after the transfer, strobes every 4th cycle.
        cycle(8'h81, 1'b1);
        dk = -1; nstb = 0; bad = 0;
        for (k = 1; k <= 34; k++) begin
            cycle(8'h00, 1'b0);
            if (s_done[1] && dk < 0) dk = k;
            if (s_stb[1]) begin
                nstb++;
                if (k % 4 != 0) bad++;
            end
            if (k == 33 && s_busy[1]) bad++;
        end
        chk("div4 done cycle", dk, 32);
        chk("div4 strobe count", nstb, 8);
        chk("div4 strobe spacing / idle", bad, 0);
        drain();

        // 8'h3C then 8'hC3 back to back on instance 0: 16 contiguous strobes.
        cycle(8'h3C, 1'b1);
        nstb = 0; d1 = -1; d2 = -1;
        for (k = 1; k <= 17; k++) begin
            cycle((k == 1) ? 8'hC3 : 8'h00, k == 1);
            if (k <= 16 && s_stb[0]) nstb++;
            if (k == 17) chk("stream stops", {31'd0, s_stb[0]}, 32'd0);
            if (s_done[0]) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
        end
        chk("stream strobes", nstb, 16);
        chk("stream done 1", d1, 8);
        chk("stream done 2", d2, 16);
        drain();

        // DIV=2, GAP=3 on instance 2: second byte held, 3-cycle gap, ready back on reload.
        cycle(8'hB7, 1'b1);
        cycle(8'h4E, 1'b1);
        chk("gap ready before hold", {31'd0, s_ready[2]}, 32'd1);
        for (k = 2; k <= 21; k++) begin
            cycle(8'h00, 1'b0);
            if (k == 2)  chk("gap hold full", {31'd0, s_ready[2]}, 32'd0);
            if (k >= 17 && k <= 19) begin
                chk($sformatf("gap k%0d", k), {28'd0, s_sout[2], s_stb[2], s_busy[2],
                    s_ready[2]}, 32'b0010);
            end
            if (k == 20) chk("gap reload ready", {30'd0, s_ready[2], s_busy[2]}, 32'b11);
        end
        drain();

        // Reset during bit 4 of 8'hFF with a byte held.
        cycle(8'hFF, 1'b1);
        cycle(8'h5A, 1'b1);
        for (k = 2; k <= 8; k++) begin
            cycle(8'h00, 1'b0);
            if (k == 2) chk("pre-reset hold full", {31'd0, s_ready[2]}, 32'd0);
        end
        chk("pre-reset busy", {31'd0, busy[2]}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset outputs", {17'd0, sout, stb, done, busy, ready}, 32'd0);
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);
        rst = 1'b1;
        cycle(8'h00, 1'b0);
        chk("post-reset busy", {29'd0, s_busy}, 32'd0);
        chk("post-reset ready", {29'd0, s_ready}, 32'd7);
        bad = 0;
        for (k = 0; k < 30; k++) begin
            cycle(8'h00, 1'b0);
            if ((s_stb | s_done | s_busy) != 3'b000) bad++;
        end
        chk("no stray activity after reset", bad, 0);

        // Random traffic against the timeline model.
        for (k = 0; k < 1500; k++) begin
            cycle(8'($urandom), $urandom_range(0, 3) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
